// File: rtl/int_muldiv_unit.sv
// Iterative integer multiply/divide unit with HI/LO result registers.
// It computes one multiplier bit (shift-add) or one quotient bit (restoring
// divide) per cycle, working on operand magnitudes. A final FIX cycle then
// applies the sign correction for the signed operations.
module int_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_ld,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // op[1] selects divide, op[0] selects signed
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d; // partial product high / remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d; // multiplier bits / dividend->quotient
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  // Datapath helpers
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  // Operand magnitudes and one iteration of each algorithm
  always_comb begin
    mag_a     = (op[0] && a[WIDTH-1]) ? -a : a;
    mag_b     = (op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // The true difference is below the divisor, so a WIDTH-bit wrap is exact.
    div_rem   = div_shift[WIDTH-1:0] - opnd_q;
    prod_mag  = {acc_hi_q, acc_lo_q};
    prod_res  = (op_q[0] && (sign_a_q ^ sign_b_q)) ? -prod_mag : prod_mag;
    quo_res   = (op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_lo_q : acc_lo_q;
    rem_res   = (op_q[0] && sign_a_q) ? -acc_hi_q : acc_hi_q;
  end

  // Next-state logic for the control FSM and all datapath registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d     = op;
          sign_a_d = op[0] & a[WIDTH-1];
          sign_b_d = op[0] & b[WIDTH-1];
          cnt_d    = '0;
          acc_hi_d = '0;
          if (op[1] && (b == '0)) begin
            // Divide by zero short-circuits straight to completion.
            opnd_d   = '0;
            acc_lo_d = '0;
            hi_d     = a;
            lo_d     = '1;
            dz_d     = 1'b1;
            state_d  = DONE;
          end else begin
            opnd_d   = op[1] ? mag_b : mag_a;
            acc_lo_d = op[1] ? mag_a : mag_b;
            dz_d     = 1'b0;
            state_d  = CALC;
          end
        end else if (hilo_ld) begin
          hi_d = hi_in;
          lo_d = lo_in;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[1]) begin
          acc_hi_d = div_ge ? div_rem : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (op_q[1]) begin
          hi_d = rem_res;
          lo_d = quo_res;
        end else begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign dz   = dz_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_int_muldiv_unit.sv
// Directed-vector bench for int_muldiv_unit at WIDTH=32.
module tb_int_muldiv_unit;
  localparam int W = 32;
  localparam logic [1:0] MULTU = 2'b00;
  localparam logic [1:0] MULT  = 2'b01;
  localparam logic [1:0] DIVU  = 2'b10;
  localparam logic [1:0] DIV   = 2'b11;

  logic         clk = 1'b0;
  logic         reset, start, hilo_ld;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi_in, lo_in;
  logic         busy, done, dz;
  logic [W-1:0] HI, LO;

  int n_vec  = 0;
  int n_miss = 0;

  int_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hilo_ld(hilo_ld), .hi_in(hi_in), .lo_in(lo_in),
    .busy(busy), .done(done), .dz(dz), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges waited until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz, input int elat);
    int lat;
    logic [W-1:0] prev_hi, prev_lo;
    prev_hi = HI;
    prev_lo = LO;
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, (elat != 0));
    if (elat != 0) begin
      chk({tag, "_hold_hi"}, HI, prev_hi);
      chk({tag, "_hold_lo"}, LO, prev_lo);
    end
    wait_done(lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_hi"}, HI, eh);
    chk({tag, "_lo"}, LO, el);
    chk({tag, "_dz"}, dz, edz);
    chk({tag, "_idle"}, busy, 0);
    tick();
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int npulse;
    logic [W-1:0] got_hi, got_lo;
    logic got_dz;

    reset = 1'b0; start = 1'b0; op = MULTU; a = '0; b = '0;
    hilo_ld = 1'b0; hi_in = '0; lo_in = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    reset = 1'b1;

    run_op("mult_3xm5", MULT, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
    run_op("divu_100_7", DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 33);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("div_7_m2", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("div_by0", DIV, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("div_m7_m2", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 33);
    run_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);
    run_op("mult_min_min", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33);
    run_op("divu_by0", DIVU, 32'h0000_00AA, 32'h0000_0000, 32'h0000_00AA, 32'hFFFF_FFFF, 1'b1, 0);

    // start and hilo_ld together: start wins; then a load in the DONE cycle keeps dz
    op = DIV; a = 32'h0000_0055; b = '0; start = 1'b1;
    hilo_ld = 1'b1; hi_in = 32'h0000_1111; lo_in = 32'h0000_2222;
    tick();
    start = 1'b0;
    chk("both_done", done, 1);
    chk("both_hi", HI, 32'h0000_0055);
    chk("both_lo", LO, 32'hFFFF_FFFF);
    hi_in = 32'h0000_0F0F; lo_in = 32'h0000_F0F0;
    tick();
    hilo_ld = 1'b0;
    chk("ld_hi", HI, 32'h0000_0F0F);
    chk("ld_lo", LO, 32'h0000_F0F0);
    chk("ld_dz_kept", dz, 1);

    // MULTU max*max with an ignored second start five cycles in
    op = MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    op = DIVU; a = 32'h0000_1234; b = '0; start = 1'b1;
    tick();
    start = 1'b0;
    npulse = 0; got_hi = '0; got_lo = '0; got_dz = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        npulse++;
        got_hi = HI; got_lo = LO; got_dz = dz;
      end
      tick();
    end
    chk("ign_pulses", npulse, 1);
    chk("ign_hi", got_hi, 32'hFFFF_FFFE);
    chk("ign_lo", got_lo, 32'h0000_0001);
    chk("ign_dz", got_dz, 0);

    // Reset mid-DIVU, then a direct load
    op = DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("abort_busy_before", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    chk("abort_busy", busy, 0);
    hilo_ld = 1'b1; hi_in = 32'hABCD_EF01; lo_in = 32'h1001_00C0;
    tick();
    hilo_ld = 1'b0;
    chk("abort_ld_hi", HI, 32'hABCD_EF01);
    chk("abort_ld_lo", LO, 32'h1001_00C0);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) npulse++;
      tick();
    end
    chk("abort_pulses", npulse, 0);
    chk("abort_hold_hi", HI, 32'hABCD_EF01);

    // hilo_ld ignored while busy, then back-to-back start in the DONE cycle
    op = MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    hilo_ld = 1'b1; hi_in = 32'h0000_DEAD; lo_in = 32'h0000_BEEF;
    repeat (3) tick();
    hilo_ld = 1'b0;
    wait_done(lat);
    chk("b2b1_lat", lat + 3, 33);
    chk("b2b1_hi", HI, 32'h0000_0000);
    chk("b2b1_lo", LO, 32'h0000_0006);
    op = MULTU; a = 32'd4; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b2_busy", busy, 1);
    wait_done(lat);
    chk("b2b2_lat", lat, 33);
    chk("b2b2_hi", HI, 32'h0000_0000);
    chk("b2b2_lo", LO, 32'h0000_0014);
    tick();
    chk("b2b2_pulse", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
